// File: rtl/cdb_pkg.sv
// cdb_pkg: shared common-data-bus widths, the empty-tag value and the broadcast record
package cdb_pkg;
  localparam int LABEL_W = 4;
  localparam int DATA_W = 32;
  localparam int NO_LABEL = 0;
  typedef struct packed {
    logic en;
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0] data;
  } cdb_bc_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit result requests in, CDB broadcast and grants out
interface cdb_arbiter_if #(
  parameter int NREQ = 4,
  parameter int LABEL_W = cdb_pkg::LABEL_W,
  parameter int DATA_W = cdb_pkg::DATA_W
);
  logic [NREQ-1:0] req;
  logic [NREQ*LABEL_W-1:0] reqLabel;
  logic [NREQ*DATA_W-1:0] reqData;
  logic [NREQ-1:0] ack;
  logic BCEN;
  logic [LABEL_W-1:0] BClabel;
  logic [DATA_W-1:0] BCdata;
  logic labelErr;
  logic [15:0] bcCount;
  modport master (output req, reqLabel, reqData, input ack, BCEN, BClabel, BCdata, labelErr, bcCount);
  modport slave (input req, reqLabel, reqData, output ack, BCEN, BClabel, BCdata, labelErr, bcCount);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting one past the last grant
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid,
  output logic [PW-1:0] idx
);
  // Modulo keeps the wrapped index inside 0..N-1 even when N is not a power of two
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % N);
  endfunction
  // Scan from farthest to nearest so the candidate closest after ptr is written last and wins
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--) if (req[wrap(ptr, k)]) idx = wrap(ptr, k);
    valid = |req;
    gnt = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter with registered broadcast and label-0 drop flag
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LABEL_W = cdb_pkg::LABEL_W,
  parameter int DATA_W = cdb_pkg::DATA_W
) (
  input logic clk,
  input logic RST,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  typedef struct packed {
    logic en;
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0] data;
  } bc_t;
  logic [PW-1:0] rr_ptr, win_idx;
  logic [NREQ-1:0] gnt;
  logic win_vld, hit, drop, label_err;
  logic [LABEL_W-1:0] win_label;
  logic [DATA_W-1:0] win_data;
  logic [15:0] bc_count;
  bc_t bc;
  rr_arbiter #(.N(NREQ)) u_rr (
    .req(bus.req),
    .ptr(rr_ptr),
    .gnt(gnt),
    .valid(win_vld),
    .idx(win_idx)
  );
  assign win_label = bus.reqLabel[win_idx*LABEL_W +: LABEL_W];
  assign win_data = bus.reqData[win_idx*DATA_W +: DATA_W];
  assign hit = win_vld && win_label != LABEL_W'(NO_LABEL);
  assign drop = win_vld && win_label == LABEL_W'(NO_LABEL);
  assign bus.ack = RST ? '0 : gnt;
  assign bus.BCEN = bc.en;
  assign bus.BClabel = bc.label;
  assign bus.BCdata = bc.data;
  assign bus.labelErr = label_err;
  assign bus.bcCount = bc_count;
  // Register the winner's broadcast; label 0 is acked but never reaches the bus
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      bc <= '0;
      label_err <= 1'b0;
      bc_count <= '0;
      rr_ptr <= PW'(NREQ - 1);
    end else begin
      bc.en <= hit;
      if (win_vld) rr_ptr <= win_idx;
      if (hit) begin
        bc.label <= win_label;
        bc.data <= win_data;
        bc_count <= bc_count + 16'd1;
      end
      if (drop) label_err <= 1'b1;
    end
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the shared common data bus (CDB) among NREQ functional-unit result ports; one result is broadcast per cycle.
- Drives the BCEN / BClabel / BCdata broadcast inputs of every reservation station and the register status logic.
- Uses a round-robin grant with registered broadcast outputs.
- Enforces the tag convention "label 0 = no pending producer" by dropping and flagging label-0 requests.

Parameters:
- NREQ, 4, number of requesting functional units (2..8).
- LABEL_W, 4, tag width; matches reservation-station Qj/Qk.
- DATA_W, 32, result width.

Ports:
- clk  in  1  rising-edge clock.
- RST  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-unit result-valid request.
- reqLabel  in  NREQ*LABEL_W  packed tags; unit i occupies bits [i*LABEL_W +: LABEL_W].
- reqData  in  NREQ*DATA_W  packed results; same packing as reqLabel.
- ack  out  NREQ  one-hot grant for the current cycle; combinational.
- BCEN  out  1  broadcast valid; registered.
- BClabel  out  LABEL_W  broadcast tag; registered.
- BCdata  out  DATA_W  broadcast value; registered.
- labelErr  out  1  sticky flag: a label-0 request was dropped.
- bcCount  out  16  number of broadcasts issued; wraps.

Behaviour:
- Reset (RST=1, asynchronous): BCEN=0, BClabel=0, BCdata=0, labelErr=0, bcCount=0, rrPtr=NREQ-1. With rrPtr=NREQ-1, unit 0 has highest priority on the first arbitration.
- Grant selection (combinational):
  - Search starts at index rrPtr+1 mod NREQ and wraps.
  - The first i with req[i]=1 is the winner; ack = onehot(winner).
  - If no req is asserted, ack=0.
  - ack is forced to 0 while RST=1.
- Handshake:
  - A unit holds req, reqLabel and reqData stable until it samples ack=1 at a clock edge.
  - It deasserts req, or presents the next result, in the following cycle.
  - A unit may request in back-to-back cycles; it is granted again only after every other requesting unit has been served.
- Latency: the winner at edge N appears on BCEN/BClabel/BCdata for exactly one cycle, after edge N.
- At each edge with a winner w:
  - rrPtr <= w.
  - If reqLabel[w] != 0: BCEN<=1, BClabel<=reqLabel[w], BCdata<=reqData[w], bcCount<=bcCount+1 (mod 2^16).
  - If reqLabel[w] == 0: the request is acked but dropped; BCEN<=0, labelErr<=1 (cleared only by RST); rrPtr still advances.
- No winner: BCEN<=0; BClabel and BCdata hold their previous values; rrPtr holds.
- Broadcast output is never valid on two consecutive cycles from the same unit while another unit is requesting (fairness bound: a waiting unit is served within NREQ cycles).
- Single requester: granted every cycle, giving a continuous BCEN=1 stream.
- Reset mid-broadcast: outputs clear immediately (asynchronous); the pending ack is lost and the unit re-presents its request after reset.
- Width rules: rrPtr is $clog2(NREQ) bits. The wrap computation must be correct for non-power-of-two NREQ, e.g. NREQ=3 never yields index 3.

Decomposition:
- Shared package (cdb_pkg): LABEL_W, DATA_W, NO_LABEL=0, a packed CDB broadcast struct {en, label, data}.
- Sub-module rr_arbiter: pure combinational round-robin picker. Inputs: req vector and last-grant pointer. Outputs: one-hot grant, valid, encoded index. Reusable for issue-port arbitration.

Test Plan:
- Reset, then a single req[2]=1 with label 5, data 0xDEADBEEF → ack=0100 in that cycle; next cycle BCEN=1, BClabel=5, BCdata=0xDEADBEEF, bcCount=1.
- All four req held high, labels 1..4 → ack sequence 0001, 0010, 0100, 1000, 0001; BClabel sequence 1, 2, 3, 4, 1 on consecutive cycles.
- req[0] continuous, req[3] asserted at cycle 3 → unit 3 is acked no later than cycle 4, and unit 0 resumes after it.
- req[1]=1 with label 0 → ack[1]=1; next cycle BCEN=0, labelErr=1; bcCount unchanged; rrPtr=1, so a following req[0]/req[2] pair grants unit 2 first.
- All units granted back-to-back, then req cleared → BCEN falls to 0 one cycle after the last ack; BClabel/BCdata hold their last values.
- RST pulsed asynchronously mid-cycle during a stream → BCEN, labelErr and bcCount go to 0 without waiting for a clock edge; the first post-reset grant goes to the lowest-index requester.
